// File: rtl/tagger_pkg.sv
// tagger_pkg: shared states, marker opcodes and marker word builder
package tagger_pkg;
  typedef enum logic [2:0] {ST_DISABLED, ST_START, ST_RUN, ST_LOSS, ST_STOP} state_t;
  localparam logic [7:0] MARKER_PREFIX = 8'hFF;
  localparam logic [7:0] OP_START = 8'h00;
  localparam logic [7:0] OP_OVERFLOW = 8'h01;
  localparam logic [7:0] OP_HEARTBEAT = 8'h02;
  localparam logic [7:0] OP_STOP = 8'h03;
  function automatic logic [31:0] marker(input logic [7:0] op, input logic [15:0] arg);
    return {MARKER_PREFIX, op, arg};
  endfunction
endpackage

// File: rtl/tagger_sat_counter.sv
// tagger_sat_counter: saturating up-counter with clear and load-one
module tagger_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic         load1,
  output logic [W-1:0] q
);
  // clear beats load-one beats increment; increment sticks at all-ones
  always_ff @(posedge clk)
    if (rst || clr) q <= '0;
    else if (load1) q <= W'(1);
    else if (inc && q != '1) q <= q + W'(1);
endmodule

// File: rtl/tagger_stream_scheduler.sv
// tagger_stream_scheduler: merges tag words with START/OVERFLOW/HEARTBEAT/STOP markers into a FIFO
module tagger_stream_scheduler
  import tagger_pkg::*;
#(
  parameter int HB_BITS = 16
) (
  input  logic               trig_clk,
  input  logic               rst,
  input  logic               tag_write_enable,
  input  logic [31:0]        tag_write_data,
  output logic               tag_write_full,
  input  logic               fifo_full,
  output logic               fifo_write_enable,
  output logic [31:0]        fifo_write_data,
  input  logic               conf_enable,
  input  logic [HB_BITS-1:0] conf_heartbeat_period,
  output logic [31:0]        stat_lost_total
);
  state_t state, state_nx;
  logic [HB_BITS-1:0] hb_cnt, hb_seq;
  logic hb_pend, hb_pend_nx, hb_wrap, hb_emit, hb_clr;
  logic [15:0] lost16;
  logic lost_inc, lost_clr, lost_ld1, stat_inc;
  logic we_nx, full_nx;
  logic [31:0] data_nx;
  assign hb_wrap = state == ST_RUN && conf_heartbeat_period != '0 &&
                   hb_cnt == conf_heartbeat_period - HB_BITS'(1);
  // next state, FIFO write decision and drop accounting
  always_comb begin
    state_nx = state;
    we_nx = 1'b0;
    data_nx = fifo_write_data;
    lost_inc = 1'b0;
    lost_clr = 1'b0;
    lost_ld1 = 1'b0;
    stat_inc = 1'b0;
    hb_clr = 1'b0;
    hb_emit = 1'b0;
    case (state)
      ST_DISABLED: state_nx = conf_enable ? ST_START : ST_DISABLED;
      ST_START:
        if (!conf_enable) state_nx = ST_DISABLED;
        else if (!fifo_full) begin
          we_nx = 1'b1;
          data_nx = marker(OP_START, 16'h0);
          hb_clr = 1'b1;
          state_nx = ST_RUN;
        end
      ST_RUN:
        if (!conf_enable) begin
          lost_inc = tag_write_enable;
          stat_inc = tag_write_enable;
          state_nx = ST_STOP;
        end else if (tag_write_enable && !fifo_full) begin
          we_nx = 1'b1;
          data_nx = tag_write_data;
        end else if (tag_write_enable) begin
          lost_ld1 = 1'b1;
          stat_inc = 1'b1;
          state_nx = ST_LOSS;
        end else if (hb_pend && !fifo_full) begin
          we_nx = 1'b1;
          data_nx = marker(OP_HEARTBEAT, 16'(hb_seq));
          hb_emit = 1'b1;
        end
      ST_LOSS: begin
        stat_inc = tag_write_enable;
        if (!conf_enable) begin
          lost_inc = tag_write_enable;
          state_nx = ST_STOP;
        end else if (!fifo_full) begin
          we_nx = 1'b1;
          data_nx = marker(OP_OVERFLOW, lost16);
          lost_ld1 = tag_write_enable;
          lost_clr = !tag_write_enable;
          state_nx = tag_write_enable ? ST_LOSS : ST_RUN;
        end else lost_inc = tag_write_enable;
      end
      ST_STOP: begin
        stat_inc = tag_write_enable;
        lost_inc = tag_write_enable;
        if (!fifo_full) begin
          we_nx = 1'b1;
          data_nx = marker(OP_STOP, lost16);
          lost_clr = 1'b1;
          state_nx = ST_DISABLED;
        end
      end
      default: state_nx = ST_DISABLED;
    endcase
    hb_pend_nx = (state_nx == ST_STOP || hb_clr) ? 1'b0 : hb_wrap | (hb_pend & ~hb_emit);
    full_nx = state_nx != ST_RUN || fifo_full || hb_pend_nx;
  end
  // state and registered outputs
  always_ff @(posedge trig_clk)
    if (rst) begin
      state <= ST_DISABLED;
      fifo_write_enable <= 1'b0;
      fifo_write_data <= '0;
      tag_write_full <= 1'b1;
    end else begin
      state <= state_nx;
      fifo_write_enable <= we_nx;
      fifo_write_data <= data_nx;
      tag_write_full <= full_nx;
    end
  // heartbeat cycle counter, sequence number and pending flag
  always_ff @(posedge trig_clk)
    if (rst || hb_clr) begin
      hb_cnt <= '0;
      hb_seq <= '0;
      hb_pend <= 1'b0;
    end else begin
      if (state == ST_RUN) hb_cnt <= (hb_wrap || conf_heartbeat_period == '0) ? '0 : hb_cnt + HB_BITS'(1);
      hb_seq <= hb_emit ? hb_seq + HB_BITS'(1) : hb_seq;
      hb_pend <= hb_pend_nx;
    end
  tagger_sat_counter #(.W(16)) u_lost (
    .clk(trig_clk), .rst(rst), .inc(lost_inc), .clr(lost_clr), .load1(lost_ld1), .q(lost16)
  );
  tagger_sat_counter #(.W(32)) u_stat (
    .clk(trig_clk), .rst(rst), .inc(stat_inc), .clr(1'b0), .load1(1'b0), .q(stat_lost_total)
  );
endmodule

// File: tb/tb_tagger_stream_scheduler.sv
// tb_tagger_stream_scheduler: directed self-checking bench for the tag stream scheduler
module tb_tagger_stream_scheduler;
  logic trig_clk = 1'b0;
  logic rst = 1'b1;
  logic tag_write_enable = 1'b0;
  logic [31:0] tag_write_data = '0;
  logic tag_write_full;
  logic fifo_full = 1'b0;
  logic fifo_write_enable;
  logic [31:0] fifo_write_data;
  logic conf_enable = 1'b0;
  logic [15:0] conf_heartbeat_period = '0;
  logic [31:0] stat_lost_total;
  int compared = 0;
  int mismatched = 0;
  tagger_stream_scheduler #(.HB_BITS(16)) dut (
    .trig_clk(trig_clk), .rst(rst), .tag_write_enable(tag_write_enable), .tag_write_data(tag_write_data),
    .tag_write_full(tag_write_full), .fifo_full(fifo_full), .fifo_write_enable(fifo_write_enable),
    .fifo_write_data(fifo_write_data), .conf_enable(conf_enable),
    .conf_heartbeat_period(conf_heartbeat_period), .stat_lost_total(stat_lost_total)
  );
  always #5 trig_clk = ~trig_clk;
  task automatic step();
    @(posedge trig_clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(fifo_write_enable), 32'd0);
    check({tag, "_data"}, fifo_write_data, 32'd0);
    check({tag, "_full"}, 32'(tag_write_full), 32'd1);
    check({tag, "_lost"}, stat_lost_total, 32'd0);
  endtask
  task automatic wait_write(input string tag, input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!fifo_write_enable && n < limit);
    if (!fifo_write_enable) check({tag, "_timeout"}, 32'(n), 32'(limit + 1));
  endtask
  initial begin
    int n;
    logic any_we;
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    conf_enable = 1'b1;
    step();
    check("disabled_to_start_no_write", 32'(fifo_write_enable), 32'd0);
    step();
    check("start_we", 32'(fifo_write_enable), 32'd1);
    check("start_word", fifo_write_data, 32'hFF00_0000);
    check("run_full_low", 32'(tag_write_full), 32'd0);
    tag_write_enable = 1'b1;
    tag_write_data = 32'h1234_5678;
    step();
    check("tag1_we", 32'(fifo_write_enable), 32'd1);
    check("tag1_word", fifo_write_data, 32'h1234_5678);
    tag_write_data = 32'h0000_0001;
    step();
    check("tag2_we", 32'(fifo_write_enable), 32'd1);
    check("tag2_word", fifo_write_data, 32'h0000_0001);
    tag_write_enable = 1'b0;
    step();
    check("idle_no_write", 32'(fifo_write_enable), 32'd0);
    any_we = 1'b0;
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tag_write_enable = (i % 2) == 0;
      tag_write_data = 32'(i);
      step();
      any_we |= fifo_write_enable;
    end
    check("no_write_while_full", 32'(any_we), 32'd0);
    check("loss_backpressure", 32'(tag_write_full), 32'd1);
    fifo_full = 1'b0;
    tag_write_enable = 1'b0;
    step();
    check("overflow_we", 32'(fifo_write_enable), 32'd1);
    check("overflow_word", fifo_write_data, 32'hFF01_0005);
    check("lost_total_5", stat_lost_total, 32'd5);
    tag_write_enable = 1'b1;
    tag_write_data = 32'hABCD_EF01;
    step();
    check("after_loss_tag", fifo_write_data, 32'hABCD_EF01);
    check("after_loss_we", 32'(fifo_write_enable), 32'd1);
    tag_write_enable = 1'b0;
    conf_heartbeat_period = 16'd100;
    wait_write("hb0", 150, n);
    check("hb0_word", fifo_write_data, 32'hFF02_0000);
    wait_write("hb1", 150, n);
    check("hb1_word", fifo_write_data, 32'hFF02_0001);
    check("hb_spacing", 32'(n), 32'd100);
    any_we = 1'b0;
    for (int i = 0; i < 99; i++) begin
      step();
      any_we |= fifo_write_enable;
    end
    check("hb_gap_no_write", 32'(any_we), 32'd0);
    tag_write_enable = 1'b1;
    tag_write_data = 32'hCAFE_F00D;
    step();
    check("due_tag_word", fifo_write_data, 32'hCAFE_F00D);
    tag_write_enable = 1'b0;
    step();
    check("deferred_hb_we", 32'(fifo_write_enable), 32'd1);
    check("deferred_hb_word", fifo_write_data, 32'hFF02_0002);
    conf_heartbeat_period = '0;
    rst = 1'b1;
    step();
    check_reset_outputs("reset2");
    rst = 1'b0;
    step();
    step();
    check("restart_word", fifo_write_data, 32'hFF00_0000);
    fifo_full = 1'b1;
    tag_write_enable = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    fifo_full = 1'b0;
    tag_write_enable = 1'b0;
    step();
    check("sat_overflow_word", fifo_write_data, 32'hFF01_FFFF);
    check("lost_total_70000", stat_lost_total, 32'd70000);
    fifo_full = 1'b1;
    tag_write_enable = 1'b1;
    for (int i = 0; i < 3; i++) step();
    conf_enable = 1'b0;
    tag_write_enable = 1'b0;
    fifo_full = 1'b0;
    step();
    check("to_stop_no_write", 32'(fifo_write_enable), 32'd0);
    step();
    check("stop_we", 32'(fifo_write_enable), 32'd1);
    check("stop_word", fifo_write_data, 32'hFF03_0003);
    tag_write_enable = 1'b1;
    any_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      any_we |= fifo_write_enable;
    end
    check("disabled_no_write", 32'(any_we), 32'd0);
    check("disabled_not_counted", stat_lost_total, 32'd70003);
    check("disabled_full", 32'(tag_write_full), 32'd1);
    tag_write_enable = 1'b0;
    conf_enable = 1'b1;
    step();
    step();
    check("third_start_word", fifo_write_data, 32'hFF00_0000);
    fifo_full = 1'b1;
    tag_write_enable = 1'b1;
    step();
    fifo_full = 1'b0;
    tag_write_enable = 1'b0;
    rst = 1'b1;
    step();
    check_reset_outputs("reset_in_loss");
    rst = 1'b0;
    conf_enable = 1'b0;
    step();
    check_reset_outputs("after_reset_in_loss");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tagger_stream_scheduler.md
TAGGER_STREAM_SCHEDULER -- requirements
Module: tagger_stream_scheduler

Interface
REQ-001 SHALL have parameter HB_BITS, default 16: width of the heartbeat period and heartbeat sequence number.
REQ-002 SHALL have port trig_clk  in  1  sole clock; all logic is on its rising edge.
REQ-003 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port tag_write_enable  in  1  tag word valid from the purifier.
REQ-005 SHALL have port tag_write_data  in  32  tag word from the purifier.
REQ-006 SHALL have port tag_write_full  out  1  back-pressure to the purifier.
REQ-007 SHALL have port fifo_full  in  1  FIFO programmable-full flag, with at least 1 free slot of margin.
REQ-008 SHALL have port fifo_write_enable  out  1  FIFO write strobe.
REQ-009 SHALL have port fifo_write_data  out  32  FIFO write word.
REQ-010 SHALL have port conf_enable  in  1  run enable.
REQ-011 SHALL have port conf_heartbeat_period  in  HB_BITS  heartbeat period in cycles; 0 disables heartbeats.
REQ-012 SHALL have port stat_lost_total  out  32  saturating count of tags dropped while enabled since reset.

Function
REQ-013 SHALL register all outputs, so a FIFO write decided in cycle t appears in cycle t+1.
REQ-014 SHALL implement states DISABLED, START, RUN, LOSS, STOP.
REQ-015 SHALL use these marker words, with bits[31:24]=8'hFF and all other tag words passed unchanged:
- START = 32'hFF00_0000
- OVERFLOW = 32'hFF01_0000 | lost16
- HEARTBEAT = 32'hFF02_0000 | seq16
- STOP = 32'hFF03_0000 | lost16
REQ-016 DISABLED: drop tags without counting; tag_write_full=1; on conf_enable=1 go to START.
REQ-017 START: write START on the first cycle with fifo_full=0, then go to RUN; clear the heartbeat counter and sequence number.
REQ-018 RUN, tag valid and fifo_full=0: write the tag word.
REQ-019 RUN, tag valid and fifo_full=1:
- drop the tag;
- set lost16=1 and increment stat_lost_total;
- go to LOSS.
REQ-020 LOSS, each dropped tag: lost16 +1, saturating at 16'hFFFF; stat_lost_total +1, saturating.
REQ-021 LOSS, fifo_full=0: write OVERFLOW carrying the drops up to the previous cycle, clear lost16, go to RUN.
REQ-022 LOSS, tag arriving in the OVERFLOW emission cycle: drop it, load lost16=1, stay in LOSS.
REQ-023 tag_write_full SHALL be 1 whenever any of these holds:
- state is not RUN;
- fifo_full=1;
- a heartbeat is pending.
REQ-024 Heartbeat counter, RUN only:
- counts cycles;
- at conf_heartbeat_period-1 it wraps to 0 and sets heartbeat-pending.
REQ-025 A pending heartbeat SHALL be written on the first RUN cycle with no tag valid and fifo_full=0.
- A tag in the same cycle has priority.
- On emission, seq16 increments, wrapping at 2^16.
- The counter keeps running while the heartbeat is pending.
REQ-026 conf_enable=0 in RUN or LOSS SHALL go to STOP.
- Pending heartbeat is discarded.
- STOP waits for fifo_full=0, writes STOP carrying the current lost16, clears lost16, goes to DISABLED.
REQ-027 Tags in STOP SHALL be dropped and counted in lost16 and stat_lost_total.
REQ-028 conf_enable re-asserted during START is ignored; conf_enable=0 during START aborts to DISABLED with no marker.
REQ-029 fifo_write_enable SHALL never assert in a cycle following one where fifo_full=1 was sampled.

Reset
REQ-030 On rst=1 the block SHALL enter DISABLED and clear:
- fifo_write_enable=0 and fifo_write_data=0;
- tag_write_full=1;
- lost16, stat_lost_total, heartbeat counter, seq16 and the pending flag.
REQ-031 rst mid-operation SHALL abandon any pending marker without writing it.

Structure
REQ-032 Shared package tagger_pkg SHALL hold:
- the state enum;
- marker opcodes 8'h00–8'h03;
- the constant 8'hFF marker prefix.
REQ-033 One sub-module, tagger_sat_counter (parameterised width, inc/clear/load1, saturating), SHALL implement lost16 and stat_lost_total.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- rst, then conf_enable=1 with fifo_full=0 → exactly one write 32'hFF000000, then tags 0x12345678, 0x00000001 written unchanged in order, 1 cycle latency each.
- RUN, fifo_full=1 for 10 cycles while 5 tags arrive, then fifo_full=0 → 32'hFF010005, stat_lost_total=5, next tag passes.
- period=100, no tags → heartbeats 32'hFF020000, 32'hFF020001 written 100 cycles apart; with a tag valid on the due cycle, the heartbeat is written one cycle after the tag.
- 70000 drops in LOSS → OVERFLOW carries 16'hFFFF and stat_lost_total=70000.
- conf_enable 1→0 during LOSS with 3 drops → 32'hFF030003, then DISABLED; further tags are not counted.
- rst asserted with OVERFLOW pending → no marker written; all outputs hold their reset values the next cycle.
